// File: rtl/data_distributor_pkg.sv
// rtl/data_distributor_pkg.sv - shared constants and slot numbering for the nibble selector bus
package data_distributor_pkg;

    localparam int DATA_WIDTH = 4;
    localparam int LANES      = 4;
    localparam int BEATS      = 4;
    localparam int SLOTS      = LANES * BEATS;
    localparam int DEST_BITS  = 4;
    localparam int BUS_BITS   = LANES * DATA_WIDTH;
    localparam int WORD_BITS  = SLOTS * DATA_WIDTH;
    localparam int CNT_BITS   = $clog2(BEATS);

    typedef logic [CNT_BITS-1:0] beatT;

    // Slot numbering is shared with the selector side: beat-major, lane-minor.
    function automatic int slotIndex(input int b, input int l);
        return b * LANES + l;
    endfunction

endpackage

// File: rtl/data_distributor_nibble_scatter.sv
// rtl/data_distributor_nibble_scatter.sv - merges one beat's nibbles into the assembly buffer
module data_distributor_nibble_scatter
    import data_distributor_pkg::*;
(
    input  logic [WORD_BITS-1:0] bufIn,
    input  beatT                 beat,
    input  logic [BUS_BITS-1:0]  beatData,
    input  logic [WORD_BITS-1:0] destMap,
    output logic [WORD_BITS-1:0] bufOut
);

    always_comb begin
        int k;
        logic [DEST_BITS-1:0] dest;
        k      = 0;
        dest   = '0;
        bufOut = bufIn;
        // Ascending lane order lets the higher slot overwrite on a shared destination.
        for (int l = 0; l < LANES; l++) begin
            k    = slotIndex(int'(beat), l);
            dest = destMap[k*DEST_BITS +: DEST_BITS];
            bufOut[int'(dest)*DATA_WIDTH +: DATA_WIDTH] = beatData[l*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/data_distributor.sv
// rtl/data_distributor.sv - rebuilds a 64-bit word from a 4-beat nibble selector stream
module data_distributor
    import data_distributor_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wValid,
    input  logic [BUS_BITS-1:0]  wData,
    input  logic [WORD_BITS-1:0] wDest,
    input  logic                 wFlush,
    output logic [WORD_BITS-1:0] rData,
    output logic                 rValid,
    output logic                 rBusy
);

    localparam beatT LAST_BEAT = beatT'(BEATS - 1);

    beatT                 beatCnt;
    logic [WORD_BITS-1:0] mapReg;
    logic [WORD_BITS-1:0] buffer;
    logic [WORD_BITS-1:0] merged;
    logic                 firstBeat;

    // Beat 0 sees the live map and a cleared buffer so a frame never inherits old state.
    assign firstBeat = (beatCnt == '0);

    data_distributor_nibble_scatter uScatter (
        .bufIn    (firstBeat ? '0 : buffer),
        .beat     (beatCnt),
        .beatData (wData),
        .destMap  (firstBeat ? wDest : mapReg),
        .bufOut   (merged)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            beatCnt <= '0;
            mapReg  <= '0;
            buffer  <= '0;
            rData   <= '0;
            rValid  <= 1'b0;
            rBusy   <= 1'b0;
        end else begin
            rValid <= 1'b0;
            if (wFlush) begin
                beatCnt <= '0;
                buffer  <= '0;
                rBusy   <= 1'b0;
            end else if (wValid) begin
                buffer  <= merged;
                beatCnt <= beatCnt + beatT'(1);
                if (firstBeat) begin
                    mapReg <= wDest;
                end
                if (beatCnt == LAST_BEAT) begin
                    rData  <= merged;
                    rValid <= 1'b1;
                    rBusy  <= 1'b0;
                end else begin
                    rBusy  <= 1'b1;
                end
            end
        end
    end

endmodule
